// File: rtl/channel_group_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : channel_group_acc_ctrl_pkg
//  Description : Shared constants, FSM state encoding and lane helper for the
//                channel-group accumulation controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package channel_group_acc_ctrl_pkg;

    // Pictures processed in parallel and bits per lane at the tree output.
    localparam int PICTURE_NUM    = 1;
    localparam int WIDTH_DATA_OUT = 16;

    // Two signed lanes per picture; full beat width.
    localparam int LANES  = 2 * PICTURE_NUM;
    localparam int DATA_W = LANES * WIDTH_DATA_OUT;

    // Adder-tree latency, one cycle per add_simd stage.
    localparam int TREE_LAT = 5;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One lane of the accumulator: the first group restarts the sum, later
    // groups add on top of it. Wraps modulo 2^WIDTH_DATA_OUT like add_simd.
    function automatic logic [WIDTH_DATA_OUT-1:0] lane_acc(
        input logic                      first,
        input logic [WIDTH_DATA_OUT-1:0] acc,
        input logic [WIDTH_DATA_OUT-1:0] data
    );
        return first ? data : (acc + data);
    endfunction

endpackage : channel_group_acc_ctrl_pkg
`default_nettype wire

// File: rtl/channel_group_acc_ctrl_acc_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : channel_group_acc_ctrl_acc_out_fifo
//  Description : Small synchronous FIFO holding finished pixel sums. Exposes
//                its occupancy so the controller can grant output credit.
//                DEPTH must be a power of two (pointers wrap naturally).
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_group_acc_ctrl_acc_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    // Pop is ignored when empty; a push into a full FIFO only lands if the
    // same cycle frees a slot.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The controller's credit scheme guarantees this never happens.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && w_full && !pop));

endmodule : channel_group_acc_ctrl_acc_out_fifo
`default_nettype wire

// File: rtl/channel_group_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : channel_group_acc_ctrl
//  Description : Admits 32-channel group beats into the adder tree, tracks
//                them through the tree latency, accumulates group partial
//                sums per lane at the tree output and emits one result per
//                pixel through a credit-protected output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_group_acc_ctrl
    import channel_group_acc_ctrl_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        cfg_group_num,
    input  logic [15:0]       cfg_pixel_num,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] tree_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    // Wide enough for FIFO occupancy plus every pipe stage.
    localparam int CR_W  = 8;
    localparam int W     = WIDTH_DATA_OUT;

    state_t             r_state;
    logic [7:0]         r_cfg_group_num;
    logic [15:0]        r_cfg_pixel_num;
    logic [7:0]         r_group_cnt;
    logic [15:0]        r_pix_cnt;

    logic [TREE_LAT-1:0] r_pipe_valid;
    logic [TREE_LAT-1:0] r_pipe_first;
    logic [TREE_LAT-1:0] r_pipe_last;
    logic [DATA_W-1:0]   r_acc;

    logic               w_last_grp;
    logic               w_last_pix;
    logic               w_accept;
    logic               w_credit_ok;
    logic [CR_W-1:0]    w_last_inflight;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_empty;
    logic               w_tail_valid;
    logic               w_tail_first;
    logic               w_tail_last;
    logic [DATA_W-1:0]  w_sum;

    assign w_last_grp = (r_group_cnt == r_cfg_group_num);
    assign w_last_pix = (r_pix_cnt == r_cfg_pixel_num);

    // Count pixel-closing beats still travelling through the tree.
    always_comb begin
        w_last_inflight = '0;
        for (int i = 0; i < TREE_LAT; i++) begin
            w_last_inflight = w_last_inflight + CR_W'(r_pipe_valid[i] & r_pipe_last[i]);
        end
    end

    // A pixel-closing beat needs a guaranteed FIFO slot when it reaches the
    // tail; other beats never produce a FIFO entry and are never held back.
    assign w_credit_ok = (CR_W'(w_fifo_count) + w_last_inflight) < CR_W'(OUT_DEPTH);
    assign in_ready    = (r_state == ST_RUN) && (!w_last_grp || w_credit_ok);
    assign w_accept    = in_valid && in_ready;

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    // Layer sequencing: configuration capture, group/pixel counters, state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cfg_group_num <= '0;
            r_cfg_pixel_num <= '0;
            r_group_cnt     <= '0;
            r_pix_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state         <= ST_RUN;
                        r_cfg_group_num <= cfg_group_num;
                        r_cfg_pixel_num <= cfg_pixel_num;
                        r_group_cnt     <= '0;
                        r_pix_cnt       <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_last_grp) begin
                            r_group_cnt <= '0;
                            r_pix_cnt   <= r_pix_cnt + 16'd1;
                            if (w_last_pix) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_group_cnt <= r_group_cnt + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!(|r_pipe_valid) && w_fifo_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shadow the adder-tree latency with {valid, first, last} tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_valid <= '0;
            r_pipe_first <= '0;
            r_pipe_last  <= '0;
        end else begin
            r_pipe_valid <= {r_pipe_valid[TREE_LAT-2:0], w_accept};
            r_pipe_first <= {r_pipe_first[TREE_LAT-2:0], w_accept && (r_group_cnt == 8'd0)};
            r_pipe_last  <= {r_pipe_last[TREE_LAT-2:0],  w_accept && w_last_grp};
        end
    end

    assign w_tail_valid = r_pipe_valid[TREE_LAT-1];
    assign w_tail_first = r_pipe_first[TREE_LAT-1];
    assign w_tail_last  = r_pipe_last[TREE_LAT-1];

    // Per-lane running sum seen at the tree output.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sum[l*W +: W] = lane_acc(w_tail_first, r_acc[l*W +: W], tree_data[l*W +: W]);
    end

    // Keep the partial sum for the next group of the same pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_tail_valid) begin
            r_acc <= w_sum;
        end
    end

    // The completed sum goes straight into the FIFO on the closing beat.
    channel_group_acc_ctrl_acc_out_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_acc_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_tail_valid && w_tail_last),
        .push_data (w_sum),
        .pop       (out_valid && out_ready),
        .pop_data  (out_data),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;

endmodule : channel_group_acc_ctrl
`default_nettype wire

// File: doc/channel_group_acc_ctrl.md
Name: channel_group_acc_ctrl

Overview:
- Sequencing controller placed after the 32-input channel adder tree.
- When a layer has more than 32 input channels, each output pixel needs several 32-channel groups. This block admits those group beats into the tree and tracks them through the tree's fixed pipeline latency.
- At the tree output it accumulates the group partial sums per lane and emits one result per pixel. A valid/ready handshake on the output side carries backpressure upstream.

Parameters:
- PICTURE_NUM, 1, pictures processed in parallel (shared package value).
- WIDTH_DATA_OUT, 16, bits per lane (shared package value).
- LANES, 2*PICTURE_NUM, signed lanes per beat (derived, localparam).
- TREE_LAT, 5, adder-tree latency in cycles (one per add_simd stage).
- OUT_DEPTH, 2, output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a layer; honoured only in IDLE.
- cfg_group_num  in  8  groups per pixel minus 1; sampled on start.
- cfg_pixel_num  in  16  pixels per layer minus 1; sampled on start.
- in_valid  in  1  upstream group beat present at the tree input.
- in_ready  out  1  beat accepted this cycle when in_valid&in_ready.
- tree_data  in  LANES*WIDTH_DATA_OUT  adder-tree output; sampled TREE_LAT cycles after acceptance.
- out_valid  out  1  pixel result available.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*WIDTH_DATA_OUT  per-lane accumulated pixel sum.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the layer completes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters/flags/FIFO cleared, in_ready=0, out_valid=0, out_data=0, busy=0, done=0. The same applies when reset hits mid-layer; in-flight beats are discarded.
- FSM:
  - IDLE --start--> RUN. Latch cfg_*, group_cnt=0, pix_cnt=0.
  - RUN --accept of last group of last pixel--> DRAIN.
  - DRAIN --pipeline empty and FIFO empty--> DONE.
  - DONE --next cycle--> IDLE; done=1 only in DONE.
- start outside IDLE is ignored.
- in_ready=1 only in RUN, gated by output credit:
  - A beat with group_cnt==cfg_group_num (last group) is accepted only if FIFO occupancy plus last-beats-in-flight < OUT_DEPTH.
  - Non-last beats are never gated.
- Counters, on accept:
  - group_cnt increments and wraps to 0 after cfg_group_num.
  - On that wrap pix_cnt increments.
- Tracking pipe: a TREE_LAT-deep shift register of {valid, first, last}. first is set when group_cnt==0; last is set when group_cnt==cfg_group_num. A single-group layer has first=last=1 on every beat.
- Accumulation at pipe tail (valid=1), per lane, modulo 2^WIDTH_DATA_OUT (wrap, no saturation, matching add_simd):
  - first: acc = tree_data.
  - otherwise: acc = acc + tree_data.
  - last: the sum (tree_data when first, else acc+tree_data) is pushed to the FIFO in that cycle, without waiting for the acc register.
- Output FIFO:
  - out_valid = !empty; out_data = head entry.
  - Pop on out_valid&out_ready.
  - Push and pop in the same cycle are both allowed and leave occupancy unchanged.
  - The FIFO never overflows by credit construction; an overflow is an assertion failure.
- Latency: last-group beat accepted at cycle t → out_valid at t+TREE_LAT+1 (registered FIFO), assuming an empty FIFO.
- in_valid low mid-pixel creates a bubble; accumulation is unaffected.
- out_ready low indefinitely: at most OUT_DEPTH results are held, then in_ready drops only when a last beat is presented.

Decomposition:
- Shared package (Para.v): PICTURE_NUM, WIDTH_DATA_OUT, TREE_LAT, FSM state encodings (IDLE/RUN/DRAIN/DONE).
- One sub-module, acc_out_fifo: synchronous FIFO, width LANES*WIDTH_DATA_OUT, depth OUT_DEPTH, with count output used by the credit logic.

Test Plan:
- cfg_group_num=0, cfg_pixel_num=3, tree_data lanes = pixel index, out_ready=1 → four results 0,1,2,3; each out_valid TREE_LAT+1 cycles after its beat; done pulses once; busy falls.
- cfg_group_num=3, cfg_pixel_num=0, tree_data lanes 10,20,30,40 over 4 beats → single out_data lanes=100; first flag correctly clears acc from any prior layer's residue.
- WIDTH_DATA_OUT=16, two groups of 0x7FFF and 0x0002 → lane result 0x8001 (wrap).
- out_ready=0, cfg_group_num=0, in_valid=1 continuously → exactly OUT_DEPTH beats accepted, then in_ready=0. Raising out_ready drains in order with no loss or duplication.
- cfg_group_num=2, random in_valid gaps and out_ready toggling over 50 pixels → results match a scoreboard sum; done only after the last pop.
- rst_n asserted in RUN with 3 beats in flight → all outputs 0 immediately; start after release runs a clean layer with no stale results.
